// File: rtl/led_effect_ctrl.sv
// led_effect_ctrl: effect sequencer and PWM scheduler for an 8-LED bank.
// Owns the free-running PWM counter and the step-tick divider, produces
// per-channel levels for OFF / BREATH / FLOW / BLINK, and cross-fades
// between effects so that brightness never jumps.
//
// mode_next protocol: a one-cycle request with no ready/acknowledge.
// Every cycle it is high counts as one request; the upstream debouncer
// guarantees single-cycle pulses.
module led_effect_ctrl #(
  parameter int TICK_DIV    = 100_000,
  parameter int FLOW_STEPS  = 50,
  parameter int BLINK_STEPS = 250
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        mode_next,
  output logic [7:0]  led_out,
  output logic [1:0]  cur_mode,
  output logic        busy,
  output logic [1:0]  dbg_state,
  output logic [7:0]  dbg_fade,
  output logic [63:0] dbg_pat
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = (FLOW_STEPS > 1) ? $clog2(FLOW_STEPS) : 1;
  localparam int BW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLOW_LAST  = FW'(FLOW_STEPS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_STEPS - 1);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_RUN      = 2'd2,
    ST_FADE_OUT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      fade, fade_nxt;
  logic [1:0]      mode_nxt;
  logic [1:0]      pending, pending_nxt;
  logic            load;

  logic [7:0]      pwm_cnt;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic            adv;

  logic [7:0]      br_d;
  logic            br_up;
  logic [2:0]      flow_pos;
  logic [FW-1:0]   flow_cnt;
  logic            blink_on;
  logic [BW-1:0]   blink_cnt;

  logic [7:0][7:0] pat;
  logic [7:0]      eff [8];

  assign tick      = (tick_cnt == TICK_LAST);
  assign adv       = tick && (state != ST_OFF);
  assign busy      = (state == ST_FADE_IN) || (state == ST_FADE_OUT);
  assign dbg_state = state;
  assign dbg_fade  = fade;
  assign dbg_pat   = pat;

  // Shared PWM counter, period 256 cycles.
  always_ff @(posedge sys_clk) begin
    if (rst) pwm_cnt <= 8'd0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  // Step-tick divider: tick is high on the last count of each period.
  always_ff @(posedge sys_clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + TW'(1);
  end

  // Sequencer state register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= ST_OFF;
      fade     <= 8'd0;
      cur_mode <= 2'd0;
      pending  <= 2'd0;
    end else begin
      state    <= state_nxt;
      fade     <= fade_nxt;
      cur_mode <= mode_nxt;
      pending  <= pending_nxt;
    end
  end

  // Next-state logic; the fade step is decided from the current state, so a
  // request landing on a tick both changes state and applies the step.
  always_comb begin
    state_nxt   = state;
    fade_nxt    = fade;
    mode_nxt    = cur_mode;
    pending_nxt = pending;
    load        = 1'b0;
    case (state)
      ST_OFF: begin
        fade_nxt = 8'd0;
        if (mode_next) begin
          mode_nxt  = 2'd1;
          load      = 1'b1;
          state_nxt = ST_FADE_IN;
        end
      end
      ST_FADE_IN: begin
        if (tick) begin
          if (fade == 8'hFF) state_nxt = ST_RUN;
          else               fade_nxt  = fade + 8'd1;
        end
        if (mode_next) begin
          pending_nxt = cur_mode + 2'd1;
          state_nxt   = ST_FADE_OUT;
        end
      end
      ST_RUN: begin
        fade_nxt = 8'hFF;
        if (mode_next) begin
          pending_nxt = cur_mode + 2'd1;
          state_nxt   = ST_FADE_OUT;
        end
      end
      ST_FADE_OUT: begin
        // A request on the completing tick is counted before the load.
        if (mode_next) pending_nxt = pending + 2'd1;
        if (tick) begin
          if (fade == 8'd0) begin
            mode_nxt  = pending_nxt;
            load      = 1'b1;
            state_nxt = (pending_nxt == 2'd0) ? ST_OFF : ST_FADE_IN;
          end else begin
            fade_nxt = fade - 8'd1;
          end
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // BREATH triangle: bounces between 0 and 255 with no hold at the ends.
  always_ff @(posedge sys_clk) begin
    if (rst || load) begin
      br_d  <= 8'd0;
      br_up <= 1'b1;
    end else if (adv) begin
      if (br_up) begin
        if (br_d == 8'hFF) begin
          br_d  <= 8'hFE;
          br_up <= 1'b0;
        end else begin
          br_d <= br_d + 8'd1;
        end
      end else begin
        if (br_d == 8'd0) begin
          br_d  <= 8'd1;
          br_up <= 1'b1;
        end else begin
          br_d <= br_d - 8'd1;
        end
      end
    end
  end

  // FLOW position: one lit channel, shifted every FLOW_STEPS ticks.
  always_ff @(posedge sys_clk) begin
    if (rst || load) begin
      flow_pos <= 3'd0;
      flow_cnt <= '0;
    end else if (adv) begin
      if (flow_cnt == FLOW_LAST) begin
        flow_cnt <= '0;
        flow_pos <= flow_pos + 3'd1;
      end else begin
        flow_cnt <= flow_cnt + FW'(1);
      end
    end
  end

  // BLINK phase: toggles every BLINK_STEPS ticks, starting lit.
  always_ff @(posedge sys_clk) begin
    if (rst || load) begin
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end else if (adv) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Per-channel pattern level for the active effect.
  always_comb begin
    pat = '0;
    case (cur_mode)
      2'd1:    pat = {8{br_d}};
      2'd2:    pat[flow_pos] = 8'hFF;
      2'd3:    pat = blink_on ? {8{8'hFF}} : '0;
      default: pat = '0;
    endcase
  end

  // Effective level: upper byte of pattern x fade.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      eff[i] = 8'((16'(pat[i]) * 16'(fade)) >> 8);
    end
  end

  // Registered active-low PWM drive.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      led_out <= 8'hFF;
    end else begin
      for (int i = 0; i < 8; i++) begin
        led_out[i] <= ~(pwm_cnt < eff[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_effect_ctrl.sv
// tb_led_effect_ctrl: directed walk through every effect and transition of
// led_effect_ctrl with shortened step timing.
module tb_led_effect_ctrl;

  localparam logic [1:0] S_OFF = 2'd0;
  localparam logic [1:0] S_FIN = 2'd1;
  localparam logic [1:0] S_RUN = 2'd2;
  localparam logic [1:0] S_FOUT = 2'd3;
  localparam logic [63:0] ALL_FF = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        mode_next;
  logic [7:0]  led_out;
  logic [1:0]  cur_mode;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_fade;
  logic [63:0] dbg_pat;

  int checks;
  int failures;
  int cyc;

  led_effect_ctrl #(
    .TICK_DIV(4),
    .FLOW_STEPS(2),
    .BLINK_STEPS(3)
  ) dut (
    .sys_clk(clk),
    .rst(rst),
    .mode_next(mode_next),
    .led_out(led_out),
    .cur_mode(cur_mode),
    .busy(busy),
    .dbg_state(dbg_state),
    .dbg_fade(dbg_fade),
    .dbg_pat(dbg_pat)
  );

  // Clock and cycle index (edges since reset release).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to #1 after the edge that makes cyc == c.
  task automatic wait_to(input int c);
    int guard;
    guard = 0;
    while (cyc != c) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 20000) begin
        checks++;
        failures++;
        $error("FAIL wait_to observed=%0d expected=%0d", cyc, c);
        break;
      end
    end
  endtask

  // One-cycle request, sampled on the next edge.
  task automatic pulse();
    mode_next = 1'b1;
    @(posedge clk);
    #1;
    mode_next = 1'b0;
  endtask

  initial begin
    int bad;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    mode_next = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values and idle OFF.
    chk("rst_led", led_out, 8'hFF);
    chk("rst_mode", cur_mode, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, S_OFF);
    chk("rst_fade", dbg_fade, 8'd0);
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      #1;
      if (led_out !== 8'hFF || busy !== 1'b0 || cur_mode !== 2'd0) bad++;
    end
    chk("off_idle", 64'(bad), 64'd0);

    // OFF -> BREATH fade-in.
    pulse();
    chk("br_mode", cur_mode, 2'd1);
    chk("br_busy", busy, 1'b1);
    chk("br_state", dbg_state, S_FIN);
    chk("br_fade0", dbg_fade, 8'd0);
    wait_to(5123); chk("pwm_lit", led_out, 8'h00);
    wait_to(5124); chk("pwm_edge_dark", led_out, 8'hFF);
    wait_to(5400); chk("br_fade100", dbg_fade, 8'd100);
    chk("br_d100", dbg_pat, {8{8'd100}});
    wait_to(6020); chk("br_fade255", dbg_fade, 8'd255);
    chk("br_busy255", busy, 1'b1);
    chk("br_d255", dbg_pat, ALL_FF);
    wait_to(6024); chk("br_run_busy", busy, 1'b0);
    chk("br_run_state", dbg_state, S_RUN);
    chk("br_d254", dbg_pat, {8{8'hFE}});
    wait_to(6028); chk("br_d253", dbg_pat, {8{8'hFD}});
    wait_to(7040); chk("br_d0", dbg_pat, 64'd0);
    wait_to(7044); chk("br_d1", dbg_pat, {8{8'h01}});

    // BREATH -> FLOW.
    pulse();
    chk("fo_state", dbg_state, S_FOUT);
    chk("fo_busy", busy, 1'b1);
    chk("fo_mode", cur_mode, 2'd1);
    chk("fo_fade", dbg_fade, 8'd255);
    wait_to(7048); chk("fo_fade254", dbg_fade, 8'd254);
    wait_to(7051); chk("fo_hold254", dbg_fade, 8'd254);
    wait_to(7052); chk("fo_fade253", dbg_fade, 8'd253);
    wait_to(8064); chk("fo_fade0", dbg_fade, 8'd0);
    chk("fo_mode_kept", cur_mode, 2'd1);
    wait_to(8068); chk("fl_mode", cur_mode, 2'd2);
    chk("fl_state", dbg_state, S_FIN);
    chk("fl_pos0", dbg_pat, 64'hFF);
    wait_to(8075); chk("fl_pos0_hold", dbg_pat, 64'hFF);
    wait_to(8076); chk("fl_pos1", dbg_pat, 64'hFF00);
    wait_to(8128); chk("fl_pos7", dbg_pat, 64'hFF00_0000_0000_0000);
    wait_to(8132); chk("fl_wrap", dbg_pat, 64'hFF);
    wait_to(9092); chk("fl_run", dbg_state, S_RUN);
    chk("fl_run_busy", busy, 1'b0);
    wait_to(9093); chk("fl_led_pos0", led_out, 8'hFE);
    wait_to(9101); chk("fl_led_pos1", led_out, 8'hFD);
    wait_to(9214); chk("fl_led_pwm253", led_out, 8'h7F);
    wait_to(9215); chk("fl_led_pwm254", led_out, 8'hFF);

    // FLOW -> BLINK.
    wait_to(9216);
    pulse();
    chk("fl_fo_state", dbg_state, S_FOUT);
    wait_to(10240); chk("bl_mode", cur_mode, 2'd3);
    chk("bl_state", dbg_state, S_FIN);
    chk("bl_on0", dbg_pat, ALL_FF);
    wait_to(10251); chk("bl_on_hold", dbg_pat, ALL_FF);
    wait_to(10252); chk("bl_off", dbg_pat, 64'd0);
    wait_to(10263); chk("bl_off_hold", dbg_pat, 64'd0);
    wait_to(10264); chk("bl_on1", dbg_pat, ALL_FF);
    wait_to(11264); chk("bl_run", dbg_state, S_RUN);
    wait_to(11265); chk("bl_led_off", led_out, 8'hFF);
    wait_to(11273); chk("bl_led_on", led_out, 8'h00);

    // BLINK -> OFF.
    wait_to(11300);
    pulse();
    chk("bo_state", dbg_state, S_FOUT);
    wait_to(12320); chk("bo_fade0", dbg_fade, 8'd0);
    chk("bo_mode_kept", cur_mode, 2'd3);
    wait_to(12324); chk("off_state", dbg_state, S_OFF);
    chk("off_mode", cur_mode, 2'd0);
    chk("off_busy", busy, 1'b0);
    chk("off_pat", dbg_pat, 64'd0);
    wait_to(12325); chk("off_led", led_out, 8'hFF);

    // OFF -> BREATH, request on a fade-in tick, second request in fade-out.
    wait_to(12400);
    pulse();
    chk("b2_mode", cur_mode, 2'd1);
    wait_to(12440); chk("b2_fade10", dbg_fade, 8'd10);
    wait_to(12443);
    pulse();
    chk("b2_fo_state", dbg_state, S_FOUT);
    chk("b2_fo_fade11", dbg_fade, 8'd11);
    wait_to(12460);
    pulse();
    wait_to(12488); chk("b2_fade0", dbg_fade, 8'd0);
    chk("b2_state_fo", dbg_state, S_FOUT);
    wait_to(12492); chk("b2_blink_mode", cur_mode, 2'd3);
    chk("b2_blink_state", dbg_state, S_FIN);
    chk("b2_blink_pat", dbg_pat, ALL_FF);

    // Request on the completing fade==0 tick: pending 0 becomes 1.
    pulse();
    chk("c_fo_state", dbg_state, S_FOUT);
    chk("c_fo_fade", dbg_fade, 8'd0);
    wait_to(12495);
    pulse();
    chk("c_mode", cur_mode, 2'd1);
    chk("c_state", dbg_state, S_FIN);
    chk("c_pat", dbg_pat, 64'd0);

    // Reset in the middle of a fade-in.
    wait_to(12896); chk("r_fade100", dbg_fade, 8'd100);
    chk("r_d100", dbg_pat, {8{8'd100}});
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("r_led", led_out, 8'hFF);
    chk("r_mode", cur_mode, 2'd0);
    chk("r_busy", busy, 1'b0);
    chk("r_state", dbg_state, S_OFF);
    chk("r_fade", dbg_fade, 8'd0);
    chk("r_pat", dbg_pat, 64'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("r_idle_state", dbg_state, S_OFF);
    chk("r_idle_led", led_out, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_effect_ctrl.md
Name: led_effect_ctrl

Overview:
- Effect sequencer and PWM scheduler for the 8-LED bank, with active-low LED outputs.
- Owns the shared PWM counter and a step-tick divider.
- Generates per-channel duty for OFF, BREATH, FLOW and BLINK effects.
- A debounced key pulse cycles the effect; every switch fades the current effect out and the next effect in, so brightness never jumps.

Parameters:
- TICK_DIV, 100_000: sys_clk cycles per step tick (2 ms at 50 MHz).
- FLOW_STEPS, 50: ticks per FLOW position shift.
- BLINK_STEPS, 250: ticks per BLINK half-period.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mode_next  in  1  single-cycle pulse that requests the next effect.
- led_out  out  8  LED drive, 0 = lit.
- cur_mode  out  2  active effect: 0 OFF, 1 BREATH, 2 FLOW, 3 BLINK.
- busy  out  1  high while fading (FADE_OUT or FADE_IN).

Behaviour:
- Clock and reset: one clock, sys_clk. Reset rst is synchronous and active-high.
- Reset values: led_out=8'hFF, cur_mode=0, busy=0, state=OFF, fade=0, pwm_cnt=0, tick_cnt=0, pending=0, pattern state cleared.
- Reset mid-fade: returns to these values on the next edge.
- pwm_cnt: 8 bits, increments every cycle, wraps 255->0 (period 256 cycles).
- tick: tick_cnt counts 0..TICK_DIV-1. tick is high for one cycle when tick_cnt==TICK_DIV-1, then tick_cnt returns to 0.
- Pattern level pat[i] (8 bits per channel), advanced on tick only in RUN, FADE_OUT and FADE_IN; frozen in OFF.
  - BREATH: one shared duty d, pat[i]=d for all i. d starts at 0, direction up, steps ±1 per tick. At 255 going up, next value is 254 and direction becomes down. At 0 going down, next value is 1 and direction becomes up. No hold cycle at either end.
  - FLOW: pos 0..7, pat[pos]=255, all other channels 0. pos advances every FLOW_STEPS ticks and wraps 7->0.
  - BLINK: all channels 255 (on phase) or 0 (off phase). Phase toggles every BLINK_STEPS ticks. Starts in the on phase.
  - Loading an effect resets its pattern state (d=0 up, pos=0, blink phase on, step counters 0).
- Effective level: eff[i] = (pat[i]*fade)>>8, computed as 16-bit product, upper byte taken. Maximum eff is 254.
- Output: led_out[i] <= ~(pwm_cnt < eff[i]), registered, 1-cycle latency. eff=0 means always dark.
- FSM:
  - OFF: fade=0, led_out=8'hFF.
    - mode_next -> cur_mode=1, load BREATH, enter FADE_IN.
  - FADE_IN: fade +1 per tick.
    - Tick with fade==255 -> enter RUN.
    - mode_next -> pending=cur_mode+1 (mod 4), enter FADE_OUT; fade keeps its current value.
  - RUN: fade=255.
    - mode_next -> pending=cur_mode+1 (mod 4), enter FADE_OUT.
  - FADE_OUT: fade -1 per tick.
    - mode_next -> pending=pending+1 (mod 4); stays in FADE_OUT.
    - Tick with fade==0 -> cur_mode=pending and load its pattern. If pending==0, enter OFF; otherwise enter FADE_IN.
    - mode_next in the same cycle as this completing tick: pending is incremented first, then loaded.
- mode_next arriving in the same cycle as a fade tick: the state transition and the fade step both apply. The fade step uses the state held before the edge.
- busy = (state==FADE_IN || state==FADE_OUT).
- Full fade from 255 takes 256 ticks (about 512 ms with default parameters).
- mode_next pulses longer than one cycle count once per high cycle; the debounce block upstream guarantees single-cycle pulses.

Test Plan (TICK_DIV=4, FLOW_STEPS=2, BLINK_STEPS=3):
- Reset held 3 cycles, then released -> led_out=8'hFF, cur_mode=0, busy=0; no change over 5000 cycles.
- One mode_next from OFF -> cur_mode=1, busy=1. After 256 ticks busy=0. The duty trace climbs to 255, then 254, 253 (no hold), then after 255 more ticks reaches 0, then 1. Measured lit cycles per 256-cycle window equal eff.
- In RUN BREATH, pulse mode_next -> busy=1 and fade decrements once per tick. When fade reaches 0: cur_mode=2, FLOW starts with only led_out[0] low-capable, pos advances every 8 cycles and wraps 7->0.
- Pulse mode_next twice during FADE_OUT from BREATH -> lands in BLINK (3). Phase toggles every 12 cycles; all 8 bits move together.
- From BLINK RUN, pulse mode_next -> fade to 0, cur_mode=0, state OFF, led_out=8'hFF, busy=0.
- Assert rst mid-FADE_IN with fade=100 -> next edge: all reset values. Also cover mode_next on the same cycle as the fade==0 tick -> pending+1 is loaded.
